// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Register file with NUM_RD combinational read ports, two
//             writeback ports, a per-register busy/tag scoreboard and a
//             post-reset clear sweep that zeroes every entry.
//             Optional macro REGFILE_SB_BYPASS_EN enables same-cycle
//             forwarding of writebacks onto the read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 64,
    parameter  int NUM_RD = 2,
    parameter  int TAGW   = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    we0,
    input  logic [AW-1:0]           wa0,
    input  logic [WIDTH-1:0]        wd0,
    input  logic [TAGW-1:0]         wt0,
    input  logic                    we1,
    input  logic [AW-1:0]           wa1,
    input  logic [WIDTH-1:0]        wd1,
    input  logic [TAGW-1:0]         wt1,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_addr,
    input  logic [TAGW-1:0]         alloc_tag
);

    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [TAGW-1:0]  r_tag [DEPTH];

    logic w_run;
    logic w_wr0;
    logic w_wr1;
    logic w_alloc;
    logic w_clr0;
    logic w_clr1;

    // Qualified write/alloc strobes: only in RUN and never to register 0
    assign w_run   = (r_state == S_RUN);
    assign w_wr0   = w_run && we0 && (wa0 != '0);
    assign w_wr1   = w_run && we1 && (wa1 != '0);
    assign w_alloc = w_run && alloc_en && (alloc_addr != '0);
    // A writeback retires the producer only when the register still waits on that tag
    assign w_clr0  = w_wr0 && r_busy[wa0] && (r_tag[wa0] == wt0);
    assign w_clr1  = w_wr1 && r_busy[wa1] && (r_tag[wa1] == wt1);

    assign ready = w_run;

    // State register and sweep counter; reset restarts the sweep from entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state: sweep one entry per cycle, leave CLEAR after the last entry
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_last_idx) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_clr_cnt_nxt = r_clr_cnt;
            end
        endcase
    end

    // Data array: zero sweep in CLEAR, writebacks in RUN with port 1 last so it wins
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            if (w_wr0) begin
                r_mem[wa0] <= wd0;
            end
            if (w_wr1) begin
                r_mem[wa1] <= wd1;
            end
        end
    end

    // Scoreboard: writeback clears first, alloc applied last so it overrides a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_clr0) begin
                r_busy[wa0] <= 1'b0;
            end
            if (w_clr1) begin
                r_busy[wa1] <= 1'b0;
            end
            if (w_alloc) begin
                r_busy[alloc_addr] <= 1'b1;
                r_tag[alloc_addr]  <= alloc_tag;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic [WIDTH-1:0] w_data;
        logic             w_busy;

        assign w_addr = rd_addr[gi*AW +: AW];

        // Read mux: array contents, optionally overridden by this cycle's writeback
        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = r_busy[w_addr];
`ifdef REGFILE_SB_BYPASS_EN
            if (w_wr1 && (wa1 == w_addr)) begin
                w_data = wd1;
            end else if (w_wr0 && (wa0 == w_addr)) begin
                w_data = wd0;
            end
            if ((w_wr0 && (wa0 == w_addr)) || (w_wr1 && (wa1 == w_addr))) begin
                if (w_alloc && (alloc_addr == w_addr)) begin
                    w_busy = 1'b1;
                end else if ((w_clr0 && (wa0 == w_addr)) || (w_clr1 && (wa1 == w_addr))) begin
                    w_busy = 1'b0;
                end
            end
`endif
            if (w_addr == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data[gi*WIDTH +: WIDTH] = w_data;
        assign rd_busy[gi]                = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Self-checking bench for regfile_sb: directed scenarios plus
//             randomized traffic compared against an array-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int NUM_RD = 2;
    localparam int TAGW   = 4;
    localparam int AW     = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    ready;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic                    we0, we1, alloc_en;
    logic [AW-1:0]           wa0, wa1, alloc_addr;
    logic [WIDTH-1:0]        wd0, wd1;
    logic [TAGW-1:0]         wt0, wt1, alloc_tag;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .wt0(wt0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wt1(wt1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag)
    );

    // Reference model: plain arrays plus a count of cycles since reset release
    logic [WIDTH-1:0] m_mem  [DEPTH];
    logic             m_busy [DEPTH];
    logic [TAGW-1:0]  m_tag  [DEPTH];
    int               m_cycles;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_run();
        return m_cycles >= DEPTH;
    endfunction

    function automatic bit wb_hits(input logic [AW-1:0] a);
        return m_run() && ((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_hits(a)) return (we1 && wa1 == a) ? wd1 : wd0;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_hits(a)) begin
            if (alloc_en && alloc_addr == a) return 1'b1;
            if (m_busy[a] && ((we0 && wa0 == a && m_tag[a] == wt0) ||
                              (we1 && wa1 == a && m_tag[a] == wt1))) return 1'b0;
        end
`endif
        return m_busy[a];
    endfunction

    task automatic model_reset();
        m_cycles = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic set_idle();
        we0 = 0; we1 = 0; alloc_en = 0;
    endtask

    task automatic set_random();
        we0        = 1'($urandom_range(0, 1));
        wa0        = AW'($urandom_range(0, 7));
        wd0        = WIDTH'($urandom);
        wt0        = TAGW'($urandom_range(0, 3));
        we1        = 1'($urandom_range(0, 1));
        wa1        = AW'($urandom_range(0, 7));
        wd1        = WIDTH'($urandom);
        wt1        = TAGW'($urandom_range(0, 3));
        alloc_en   = ($urandom_range(0, 2) == 0);
        alloc_addr = AW'($urandom_range(0, 7));
        alloc_tag  = TAGW'($urandom_range(0, 3));
        for (int p = 0; p < NUM_RD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
    endtask

    // One clock: check outputs for the current inputs, then advance the model at the edge
    task automatic cycle(input bit chk_reads);
        bit c0, c1;
        #1;
        check_val("ready", {31'b0, ready}, {31'b0, m_run()});
        if (chk_reads && m_run()) begin
            for (int p = 0; p < NUM_RD; p++) begin
                check_val($sformatf("rd_data[%0d]", p), {16'b0, rd_data[p*WIDTH +: WIDTH]},
                          {16'b0, exp_data(rd_addr[p*AW +: AW])});
                check_val($sformatf("rd_busy[%0d]", p), {31'b0, rd_busy[p]},
                          {31'b0, exp_busy(rd_addr[p*AW +: AW])});
            end
        end
        @(posedge clk);
        if (m_run()) begin
            c0 = we0 && wa0 != 0 && m_busy[wa0] && m_tag[wa0] == wt0;
            c1 = we1 && wa1 != 0 && m_busy[wa1] && m_tag[wa1] == wt1;
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (c0) m_busy[wa0] = 1'b0;
            if (c1) m_busy[wa1] = 1'b0;
            if (alloc_en && alloc_addr != 0) begin
                m_busy[alloc_addr] = 1'b1;
                m_tag[alloc_addr]  = alloc_tag;
            end
        end else begin
            m_cycles++;
            if (m_run()) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
        @(negedge clk);
    endtask

    // Directed spot check of port 0 against fixed expected values (inputs assumed idle)
    task automatic peek(input string tag, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input logic b);
        rd_addr[AW-1:0] = a;
        #1;
        check_val({tag, "_data"}, {16'b0, rd_data[WIDTH-1:0]}, {16'b0, d});
        check_val({tag, "_busy"}, {31'b0, rd_busy[0]}, {31'b0, b});
    endtask

    task automatic clear_phase();
        for (int i = 0; i < DEPTH; i++) begin
            set_random();
            cycle(1'b0);
        end
    endtask

    task automatic scan_all();
        set_idle();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr[AW-1:0]    = AW'(a);
            rd_addr[2*AW-1:AW] = AW'(DEPTH - 1 - a);
            cycle(1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; wa0 = '0; wa1 = '0; alloc_addr = '0;
        wd0 = '0; wd1 = '0; wt0 = '0; wt1 = '0; alloc_tag = '0;
        set_idle();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_ready", {31'b0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep with random traffic that must be ignored, then every entry reads zero
        clear_phase();
        check_val("ready_after_sweep", {31'b0, ready}, 32'd1);
        scan_all();

        // Basic write, and write to register 0
        set_idle(); we0 = 1; wa0 = 5; wd0 = 16'h1234; rd_addr = '0;
        cycle(1'b1);
        set_idle(); peek("t2_r5", 6'd5, 16'h1234, 1'b0);
        we0 = 1; wa0 = 0; wd0 = 16'hFFFF;
        cycle(1'b1);
        set_idle(); peek("t2_r0", 6'd0, 16'h0000, 1'b0);

        // Stale writeback updates data but leaves busy; matching one clears it
        alloc_en = 1; alloc_addr = 7; alloc_tag = 3;
        cycle(1'b1);
        set_idle(); we0 = 1; wa0 = 7; wd0 = 16'hAAAA; wt0 = 2;
        cycle(1'b1);
        set_idle(); peek("t3_stale", 6'd7, 16'hAAAA, 1'b1);
        we0 = 1; wa0 = 7; wd0 = 16'hAAAB; wt0 = 3;
        cycle(1'b1);
        set_idle(); peek("t3_match", 6'd7, 16'hAAAB, 1'b0);

        // Dual write to same register: port 1 wins; alloc beats matching writeback
        we0 = 1; wa0 = 9; wd0 = 16'h0001; we1 = 1; wa1 = 9; wd1 = 16'h0002;
        cycle(1'b1);
        set_idle(); peek("t4_dual", 6'd9, 16'h0002, 1'b0);
        alloc_en = 1; alloc_addr = 11; alloc_tag = 5;
        cycle(1'b1);
        set_idle(); alloc_en = 1; alloc_addr = 11; alloc_tag = 6;
        we0 = 1; wa0 = 11; wd0 = 16'h5555; wt0 = 5;
        cycle(1'b1);
        set_idle(); peek("t4_alloc_wins", 6'd11, 16'h5555, 1'b1);
        we1 = 1; wa1 = 11; wd1 = 16'h6666; wt1 = 6;
        cycle(1'b1);
        set_idle(); peek("t4_new_tag", 6'd11, 16'h6666, 1'b0);

        // Same-cycle read of a register being written
        we0 = 1; wa0 = 4; wd0 = 16'h1111;
        cycle(1'b1);
        set_idle(); we1 = 1; wa1 = 4; wd1 = 16'hBEEF;
`ifdef REGFILE_SB_BYPASS_EN
        peek("t6_fwd", 6'd4, 16'hBEEF, 1'b0);
`else
        peek("t6_old", 6'd4, 16'h1111, 1'b0);
`endif
        cycle(1'b1);
        set_idle(); peek("t6_after", 6'd4, 16'hBEEF, 1'b0);

        // Randomized traffic over a small address window to force collisions
        for (int n = 0; n < 1500; n++) begin
            set_random();
            cycle(1'b1);
        end

        // Reset pulse mid-sweep restarts the full sweep
        set_idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_random();
            cycle(1'b0);
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        check_val("midsweep_ready", {31'b0, ready}, 32'd0);
        rst_n = 1'b1;
        clear_phase();
        check_val("ready_after_restart", {31'b0, ready}, 32'd1);
        scan_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
